// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
//
// General-purpose register file for the pipeline datapath. It provides
// NUM_READ combinational read ports, one synchronous write port (writeback
// stage), an optional write-to-read bypass, and a per-register pending-write
// scoreboard that the hazard unit uses to stall on outstanding producers.
// Register 0 can be hardwired to zero.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears registers and scoreboard
//   rd_addr        packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data        packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_pending     per port: register awaits writeback and is not bypassed
//   wr_en          writeback enable
//   wr_addr        writeback address
//   wr_data        writeback data
//   resv_en        issue-stage reservation of a destination register
//   resv_addr      register to reserve
//   flush          synchronous clear of all pending bits (data kept)
//   pending_count  population count of the pending bits
// -----------------------------------------------------------------------------
module pipe_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_READ-1:0]              rd_pending,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             resv_en,
   input  logic [ADDR_WIDTH-1:0]            resv_addr,
   input  logic                             flush,
   output logic [ADDR_WIDTH:0]              pending_count
);

   localparam int DEPTH   = 2 ** ADDR_WIDTH;
   localparam bit BYP_EN  = (BYPASS != 0);
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]      pend_q;
   logic [DEPTH-1:0]      pend_d;

   // A write to register 0 is dropped entirely when it is hardwired.
   logic wr_accept;
   assign wr_accept = wr_en && !(ZERO_EN && (wr_addr == '0));

   always_comb begin
      regs_d = regs_q;
      if (wr_accept) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // Scoreboard next state. The reservation is applied after the writeback
   // clear so that a same-cycle reserve of the register being written back
   // leaves it pending: the newer producer is still outstanding.
   always_comb begin
      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else begin
         if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
         end
         if (resv_en) begin
            pend_d[resv_addr] = 1'b1;
         end
      end
      if (ZERO_EN) begin
         pend_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pend_q <= pend_d;
      end
   end

   // Read ports: zero register first, then bypass, then stored value. Each
   // port resolves on its own, even when several ports name the same register.
   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic                  hit_zero;
      logic                  hit_byp;
      logic [DATA_WIDTH-1:0] data;

      assign addr     = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit_zero = ZERO_EN && (addr == '0);
      assign hit_byp  = BYP_EN && wr_en && (wr_addr == addr);

      always_comb begin
         if (hit_zero) begin
            data = '0;
         end else if (hit_byp) begin
            data = wr_data;
         end else begin
            data = regs_q[addr];
         end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
      // A same-cycle bypassed writeback already resolves the hazard.
      assign rd_pending[p] = !hit_zero && pend_q[addr] && !hit_byp;
   end

   // Extra MSB covers the case where every register is pending.
   always_comb begin
      pending_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pending_count = pending_count + {{ADDR_WIDTH{1'b0}}, pend_q[i]};
      end
   end

endmodule

// File: tb/tb_pipe_regfile.sv
// -----------------------------------------------------------------------------
// tb_pipe_regfile
//
// Drives two register-file instances with identical stimulus: dut_a uses
// BYPASS=1/ZERO_REG=1, dut_b uses BYPASS=0/ZERO_REG=0. A behavioural model
// (plain arrays) predicts every combinational output for each cycle. The
// driver pushes the prediction into exp_q right after changing the inputs,
// and a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_regfile;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [NR*AW-1:0] rd_addr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             resv_en;
   logic [AW-1:0]    resv_addr;
   logic             flush;

   logic [NR*DW-1:0] rd_data_a, rd_data_b;
   logic [NR-1:0]    rd_pend_a, rd_pend_b;
   logic [AW:0]      cnt_a, cnt_b;

   pipe_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                  .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_pending(rd_pend_a), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .resv_en(resv_en), .resv_addr(resv_addr),
      .flush(flush), .pending_count(cnt_a));

   pipe_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                  .BYPASS(0), .ZERO_REG(0)) dut_b (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_pending(rd_pend_b), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .resv_en(resv_en), .resv_addr(resv_addr),
      .flush(flush), .pending_count(cnt_b));

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [NR*DW-1:0] data_a;
      logic [NR*DW-1:0] data_b;
      logic [NR-1:0]    pend_a;
      logic [NR-1:0]    pend_b;
      logic [AW:0]      cnt_a;
      logic [AW:0]      cnt_b;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);
   logic [EXP_W-1:0] exp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   // Index 0 models dut_a (bypass, hardwired r0), index 1 models dut_b.
   logic [DW-1:0] m_regs [2][DEPTH];
   bit            m_pend [2][DEPTH];

   function automatic logic [DW-1:0] model_read(input int d, input logic [AW-1:0] a);
      bit zero_reg = (d == 0);
      bit bypass   = (d == 0);
      if (zero_reg && a == 0) return '0;
      if (bypass && wr_en && wr_addr == a) return wr_data;
      return m_regs[d][a];
   endfunction

   function automatic logic model_pending(input int d, input logic [AW-1:0] a);
      bit zero_reg = (d == 0);
      bit bypass   = (d == 0);
      if (zero_reg && a == 0) return 1'b0;
      if (bypass && wr_en && wr_addr == a) return 1'b0;
      return m_pend[d][a];
   endfunction

   function automatic int model_count(input int d);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_pend[d][i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) begin
            m_regs[d][i] = '0;
            m_pend[d][i] = 1'b0;
         end
   endtask

   task automatic model_commit();
      for (int d = 0; d < 2; d++) begin
         if (wr_en && !(d == 0 && wr_addr == 0)) m_regs[d][wr_addr] = wr_data;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_pend[d][i] = 1'b0;
         end else begin
            if (wr_en)   m_pend[d][wr_addr]   = 1'b0;
            if (resv_en) m_pend[d][resv_addr] = 1'b1;
         end
         if (d == 0) m_pend[d][0] = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge with the inputs for this cycle already set.
   task automatic step();
      exp_t e;
      logic [AW-1:0] a;
      if (reset) model_clear();
      for (int p = 0; p < NR; p++) begin
         a = rd_addr[p*AW +: AW];
         e.data_a[p*DW +: DW] = model_read(0, a);
         e.data_b[p*DW +: DW] = model_read(1, a);
         e.pend_a[p]          = model_pending(0, a);
         e.pend_b[p]          = model_pending(1, a);
      end
      e.cnt_a = (AW+1)'(model_count(0));
      e.cnt_b = (AW+1)'(model_count(1));
      exp_q.push_back(e);
      @(posedge clock);
      if (!reset) model_commit();
      #1;
   endtask

   task automatic idle();
      reset   = 1'b0;
      wr_en   = 1'b0;
      resv_en = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic set_resv(input logic [AW-1:0] a);
      resv_en   = 1'b1;
      resv_addr = a;
   endtask

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int p = 0; p < NR; p++) begin
               check($sformatf("a.rd_data[%0d]", p), rd_data_a[p*DW +: DW], e.data_a[p*DW +: DW]);
               check($sformatf("b.rd_data[%0d]", p), rd_data_b[p*DW +: DW], e.data_b[p*DW +: DW]);
            end
            check("a.rd_pending", DW'(rd_pend_a), DW'(e.pend_a));
            check("b.rd_pending", DW'(rd_pend_b), DW'(e.pend_b));
            check("a.pending_count", DW'(cnt_a), DW'(e.cnt_a));
            check("b.pending_count", DW'(cnt_b), DW'(e.cnt_b));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      reset     = 1'b1;
      rd_addr   = '0;
      wr_addr   = '0;
      wr_data   = '0;
      resv_addr = '0;
      @(posedge clock);
      #1;
      step();
      step();

      // Write/read/bypass on r5: old value first, then a same-cycle read.
      idle(); set_rd(5, 5); set_wr(5, 32'h1111_1111); step();
      idle(); set_rd(5, 5); set_wr(5, 32'h1234_5678); step();
      idle(); set_rd(5, 5); step();

      // Zero register: write and reserve r0 together.
      idle(); set_rd(0, 0); set_wr(0, 32'hFFFF_FFFF); set_resv(0); step();
      idle(); set_rd(0, 0); step();
      idle(); set_rd(0, 5); set_wr(0, 32'hFFFF_FFFF); step();

      // Scoreboard on r7.
      idle(); set_rd(7, 0); set_resv(7); step();
      idle(); set_rd(7, 0); step();
      idle(); set_rd(7, 7); set_wr(7, 32'h0000_00A5); step();
      idle(); set_rd(7, 5); step();
      idle(); set_rd(7, 7); set_wr(7, 32'h0000_005A); set_resv(7); step();
      idle(); set_rd(7, 0); step();

      // Flush with a competing reservation.
      idle(); set_rd(1, 2); set_wr(1, 32'h0101_0101); step();
      idle(); set_rd(2, 3); set_wr(2, 32'h0202_0202); set_resv(1); step();
      idle(); set_rd(3, 1); set_wr(3, 32'h0303_0303); set_resv(2); step();
      idle(); set_rd(1, 2); set_resv(3); step();
      idle(); set_rd(3, 4); step();
      idle(); set_rd(4, 1); flush = 1'b1; set_resv(4); step();
      idle(); set_rd(2, 3); step();
      idle(); set_rd(1, 4); step();

      // Async reset between edges with nonzero contents, then a write under reset.
      idle(); set_rd(1, 7); set_resv(9); step();
      idle(); set_rd(5, 9); reset = 1'b1; step();
      idle(); set_rd(5, 7); reset = 1'b1; set_wr(3, 32'hDEAD_BEEF); step();
      idle(); set_rd(3, 3); step();

      // Full depth: reserve every register 1..31, then write all back.
      for (int i = 1; i < DEPTH; i++) begin
         idle(); set_rd(AW'(i), AW'(i - 1)); set_resv(AW'(i)); step();
      end
      idle(); set_rd(31, 1); step();
      for (int i = 1; i < DEPTH; i++) begin
         logic [7:0] b;
         b = 8'(i);
         idle(); set_rd(AW'(i), AW'(DEPTH - i)); set_wr(AW'(i), {b, b, b, b}); step();
      end
      for (int i = 0; i < DEPTH; i += 2) begin
         idle(); set_rd(AW'(i), AW'(i + 1)); step();
      end

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] a0, a1;
         idle();
         reset     = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = AW'($urandom_range(0, DEPTH - 1));
         wr_data   = $urandom;
         resv_en   = 1'($urandom_range(0, 1));
         resv_addr = AW'($urandom_range(0, DEPTH - 1));
         a0 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
         a1 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
         set_rd(a0, a1);
         step();
      end

      idle();
      @(negedge clock);
      check("exp_q_drained", DW'(exp_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
